// File: rtl/sgdmac_desc_fetch.sv
// Scatter-gather descriptor fetcher: walks a linked list of 16-byte descriptors,
// reads each one as a 4-beat burst and hands one transfer command at a time to the data mover.
module sgdmac_desc_fetch #(
  parameter int DESC_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] start_addr_i,
  input  logic        start_i,
  output logic        done_o,
  output logic        err_o,
  output logic        arvalid_o,
  output logic [31:0] araddr_o,
  output logic [3:0]  arlen_o,
  input  logic        arready_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  output logic        rready_o,
  output logic        cmd_valid_o,
  output logic [31:0] cmd_src_o,
  output logic [31:0] cmd_dst_o,
  output logic [15:0] cmd_len_o,
  input  logic        cmd_ready_i,
  input  logic        cmd_done_i,
  output logic [2:0]  state_dbg_o
);

  // All channels use valid/ready: a transfer happens on a rising clk edge where both are 1;
  // the sender holds valid and its payload stable until that edge.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_AR  = 3'd1,
    FETCH_R   = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam logic [1:0] LAST_BEAT = 2'(DESC_WORDS - 1);

  state_t      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [27:0] nxt_q, nxt_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        beat_err;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    beat_d   = beat_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    nxt_d    = nxt_q;
    last_d   = last_q;
    err_d    = err_q;
    beat_err = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          ptr_d   = {start_addr_i[31:4], 4'h0};
          err_d   = 1'b0;
          beat_d  = 2'd0;
          state_d = FETCH_AR;
        end
      end
      FETCH_AR: begin
        if (arready_i) begin
          beat_d  = 2'd0;
          state_d = FETCH_R;
        end
      end
      FETCH_R: begin
        if (rvalid_i && rready_q) begin
          unique case (beat_q)
            2'd0: src_d = rdata_i;
            2'd1: dst_d = rdata_i;
            2'd2: len_d = rdata_i[15:0];
            2'd3: begin
              nxt_d  = rdata_i[31:4];
              last_d = rdata_i[0];
            end
          endcase
          // rlast must line up with the fourth beat exactly
          beat_err = (rresp_i != 2'b00) ||
                     ((beat_q == LAST_BEAT) ? !rlast_i : rlast_i);
          err_d  = err_q | beat_err;
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            if (err_q || beat_err) begin
              state_d = IDLE;
            end else if (len_q != 16'd0) begin
              state_d = ISSUE;
            end else if (rdata_i[0]) begin
              state_d = IDLE;
            end else begin
              ptr_d   = {rdata_i[31:4], 4'h0};
              state_d = FETCH_AR;
            end
          end
        end
      end
      ISSUE: begin
        if (cmd_ready_i) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cmd_done_i) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            ptr_d   = {nxt_q, 4'h0};
            state_d = FETCH_AR;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    arvalid_d   = (state_d == FETCH_AR);
    rready_d    = (state_d == FETCH_R);
    cmd_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 32'h0;
      beat_q      <= 2'd0;
      src_q       <= 32'h0;
      dst_q       <= 32'h0;
      len_q       <= 16'h0;
      nxt_q       <= 28'h0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      beat_q      <= beat_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      nxt_q       <= nxt_d;
      last_q      <= last_d;
      err_q       <= err_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign done_o      = (state_q == IDLE);
  assign err_o       = err_q;
  assign arvalid_o   = arvalid_q;
  assign araddr_o    = ptr_q;
  assign arlen_o     = 4'(DESC_WORDS - 1);
  assign rready_o    = rready_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_src_o   = src_q;
  assign cmd_dst_o   = dst_q;
  assign cmd_len_o   = len_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_sgdmac_desc_fetch.sv
// Bench for sgdmac_desc_fetch: memory slave and data-mover models drive the DUT,
// a monitor pops expected read addresses and commands from queues as they are presented.
module tb_sgdmac_desc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] start_addr_i = 32'h0;
  logic        start_i = 1'b0;
  logic        done_o, err_o, arvalid_o, rready_o, cmd_valid_o;
  logic [31:0] araddr_o, cmd_src_o, cmd_dst_o;
  logic [3:0]  arlen_o;
  logic [15:0] cmd_len_o;
  logic [2:0]  state_dbg;
  logic        arready_i = 1'b0, rvalid_i = 1'b0, rlast_i = 1'b0;
  logic [31:0] rdata_i = 32'h0;
  logic [1:0]  rresp_i = 2'b00;
  logic        cmd_ready_i = 1'b0, cmd_done_i = 1'b0;

  sgdmac_desc_fetch #(.DESC_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start_addr_i(start_addr_i), .start_i(start_i),
    .done_o(done_o), .err_o(err_o), .arvalid_o(arvalid_o), .araddr_o(araddr_o),
    .arlen_o(arlen_o), .arready_i(arready_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .rresp_i(rresp_i), .rlast_i(rlast_i), .rready_o(rready_o), .cmd_valid_o(cmd_valid_o),
    .cmd_src_o(cmd_src_o), .cmd_dst_o(cmd_dst_o), .cmd_len_o(cmd_len_o),
    .cmd_ready_i(cmd_ready_i), .cmd_done_i(cmd_done_i), .state_dbg_o(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int n_total = 0, n_pass = 0;
  logic [79:0] exp_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [7:0]  hist = 8'h0;
  int hist_n = 0;
  int ar_delay = 0, ar_unstable = 0, beats_taken = 0, cur_beat = -1;
  int err_beat = -1, bad_rlast_beat = -1;
  logic [31:0] err_addr = 32'h0, sl_addr = 32'h0;
  int cmd_ready_delay = 0, cmd_done_delay = 2, done_pulses = 0, ar_in_wait = 0;
  bit outstanding = 1'b0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  task automatic put_desc(input logic [31:0] a, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] l, input logic [31:0] n);
    mem[a] = s; mem[a + 32'd4] = d; mem[a + 32'd8] = l; mem[a + 32'd12] = n;
  endtask

  // ---------------- read slave ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && arvalid_o) begin
        sl_addr = araddr_o;
        for (int i = 0; i < ar_delay; i++) begin
          @(negedge clk);
          if (araddr_o !== sl_addr || arvalid_o !== 1'b1) ar_unstable++;
        end
        ar_delay = 0;
        arready_i = 1'b1;
        @(negedge clk);
        arready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
          cur_beat = b;
          rvalid_i = 1'b1;
          rdata_i  = rd_mem(sl_addr + 32'(4 * b));
          rresp_i  = (sl_addr == err_addr && b == err_beat) ? 2'b10 : 2'b00;
          rlast_i  = ((b == 3) != (b == bad_rlast_beat));
          if (rready_o) beats_taken++;
          @(negedge clk);
          if (rst) break;
        end
        cur_beat = -1;
        rvalid_i = 1'b0; rresp_i = 2'b00; rlast_i = 1'b0;
      end
    end
  end

  // ---------------- data mover ----------------
  initial begin
    int rdy_cnt, done_cnt;
    rdy_cnt = 0; done_cnt = 0;
    forever begin
      @(negedge clk);
      cmd_done_i = 1'b0;
      if (rst) begin
        cmd_ready_i = 1'b0; outstanding = 1'b0; rdy_cnt = 0; done_cnt = 0;
      end else if (cmd_ready_i) begin
        cmd_ready_i = 1'b0; outstanding = 1'b1; done_cnt = 0;
      end else if (outstanding) begin
        done_cnt++;
        if (done_cnt >= cmd_done_delay) begin
          cmd_done_i = 1'b1; outstanding = 1'b0; done_pulses++;
        end
      end else if (cmd_valid_o) begin
        if (rdy_cnt >= cmd_ready_delay) begin
          cmd_ready_i = 1'b1; rdy_cnt = 0;
        end else rdy_cnt++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (arvalid_o && arready_i) begin
          if (exp_ar_q.size() == 0) chk("ar_unexpected", {48'h0, araddr_o}, 80'h0);
          else chk("ar_addr", {48'h0, araddr_o}, {48'h0, exp_ar_q.pop_front()});
          chk("ar_len", {76'h0, arlen_o}, 80'd3);
          hist = {hist[6:0], 1'b0}; hist_n++;
        end
        if (cmd_valid_o && cmd_ready_i) begin
          if (exp_q.size() == 0) chk("cmd_unexpected", {cmd_src_o, cmd_dst_o, cmd_len_o}, 80'h0);
          else chk("cmd", {cmd_src_o, cmd_dst_o, cmd_len_o}, exp_q.pop_front());
          hist = {hist[6:0], 1'b1}; hist_n++;
        end
        if (outstanding && arvalid_o) ar_in_wait++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_chain(input logic [31:0] a);
    @(negedge clk);
    hist = 8'h0; hist_n = 0;
    start_addr_i = a; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("done_low_after_start", {79'h0, done_o}, 80'd0);
    chk("err_clear_after_start", {79'h0, err_o}, 80'd0);
  endtask

  task automatic pulse_start(input logic [31:0] a);
    @(negedge clk);
    start_addr_i = a; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #2;
      if (done_o) begin ok = 1'b1; break; end
    end
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL idle_timeout: done_o=%0b expected 1 within %0d cycles", done_o, max_cyc);
  endtask

  task automatic end_checks(input int exp_hist_n, input logic [7:0] exp_hist, input logic exp_err);
    chk("seq_len", 80'(hist_n), 80'(exp_hist_n));
    chk("seq_order", {72'h0, hist}, {72'h0, exp_hist});
    chk("err_end", {79'h0, err_o}, {79'h0, exp_err});
    chk("ar_q_empty", 80'(exp_ar_q.size()), 80'd0);
    chk("cmd_q_empty", 80'(exp_q.size()), 80'd0);
    exp_ar_q.delete(); exp_q.delete();
  endtask

  task automatic expect_single();
    exp_ar_q.push_back(32'h1000);
    exp_q.push_back({32'h2000, 32'h3000, 16'h0040});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_total++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // ---------------- directed tests ----------------
  initial begin
    int p0, b0;
    put_desc(32'h1000, 32'h2000, 32'h3000, 32'h0000_0040, 32'h1);
    put_desc(32'h0100, 32'hA000, 32'hB000, 32'hDEAD_0010, 32'h200);
    put_desc(32'h0200, 32'hA100, 32'hB100, 32'h0000_0020, 32'h300);
    put_desc(32'h0300, 32'hA200, 32'hB200, 32'h0000_0030, 32'h1);
    put_desc(32'h0400, 32'hC000, 32'hD000, 32'h0000_0008, 32'h500);
    put_desc(32'h0500, 32'hC100, 32'hD100, 32'hFFFF_0000, 32'h600);
    put_desc(32'h0600, 32'hC200, 32'hD200, 32'h0000_0018, 32'h1);
    put_desc(32'h0700, 32'hE000, 32'hF000, 32'h0000_0040, 32'h1);

    // reset values
    @(negedge clk);
    #1;
    chk("rst_done", {79'h0, done_o}, 80'd1);
    chk("rst_err", {79'h0, err_o}, 80'd0);
    chk("rst_valids", {77'h0, arvalid_o, rready_o, cmd_valid_o}, 80'd0);
    chk("rst_araddr", {48'h0, araddr_o}, 80'd0);
    chk("rst_state", {77'h0, state_dbg}, 80'd0);
    @(negedge clk);
    rst = 1'b0;

    // single descriptor
    expect_single();
    start_chain(32'h1000);
    wait_idle(500);
    end_checks(2, 8'b01, 1'b0);

    // three-descriptor chain with slow mover
    cmd_ready_delay = 5; cmd_done_delay = 20;
    p0 = done_pulses; ar_in_wait = 0;
    exp_ar_q.push_back(32'h100); exp_ar_q.push_back(32'h200); exp_ar_q.push_back(32'h300);
    exp_q.push_back({32'hA000, 32'hB000, 16'h0010});
    exp_q.push_back({32'hA100, 32'hB100, 16'h0020});
    exp_q.push_back({32'hA200, 32'hB200, 16'h0030});
    start_chain(32'h100);
    wait_idle(2000);
    chk("chain_done_pulses", 80'(done_pulses - p0), 80'd3);
    chk("chain_no_fetch_in_wait", 80'(ar_in_wait), 80'd0);
    end_checks(6, 8'b010101, 1'b0);
    cmd_ready_delay = 0; cmd_done_delay = 2;

    // zero-length middle descriptor
    exp_ar_q.push_back(32'h400); exp_ar_q.push_back(32'h500); exp_ar_q.push_back(32'h600);
    exp_q.push_back({32'hC000, 32'hD000, 16'h0008});
    exp_q.push_back({32'hC200, 32'hD200, 16'h0018});
    start_chain(32'h400);
    wait_idle(1000);
    end_checks(5, 8'b01001, 1'b0);

    // read error response on beat 1
    err_addr = 32'h700; err_beat = 1;
    b0 = beats_taken;
    exp_ar_q.push_back(32'h700);
    start_chain(32'h700);
    wait_idle(500);
    chk("err_beats_consumed", 80'(beats_taken - b0), 80'd4);
    chk("err_done", {79'h0, done_o}, 80'd1);
    end_checks(1, 8'b0, 1'b1);
    err_beat = -1;
    expect_single();
    start_chain(32'h1000);
    wait_idle(500);
    end_checks(2, 8'b01, 1'b0);

    // misplaced rlast on a middle beat and missing on the final beat
    for (int k = 0; k < 2; k++) begin
      bad_rlast_beat = (k == 0) ? 3 : 1;
      exp_ar_q.push_back(32'h1000);
      start_chain(32'h1000);
      wait_idle(500);
      end_checks(1, 8'b0, 1'b1);
    end
    bad_rlast_beat = -1;

    // stalled read address with stray start pulses
    ar_delay = 10; ar_unstable = 0; cmd_done_delay = 20;
    expect_single();
    start_chain(32'h1000);
    for (int k = 0; k < 3; k++) pulse_start(32'h700);
    for (int k = 0; k < 200 && !outstanding; k++) @(negedge clk);
    pulse_start(32'h700);
    pulse_start(32'h400);
    wait_idle(1000);
    chk("stall_araddr_stable", 80'(ar_unstable), 80'd0);
    end_checks(2, 8'b01, 1'b0);
    cmd_done_delay = 2;

    // reset during beat 2 of the first fetch
    exp_ar_q.push_back(32'h100);
    start_chain(32'h100);
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        #2;
        if (rvalid_i && cur_beat == 2) begin hit = 1'b1; break; end
      end
      chk("rst_reached_beat2", {79'h0, hit}, 80'd1);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_done", {79'h0, done_o}, 80'd1);
    chk("mid_rst_err", {79'h0, err_o}, 80'd0);
    chk("mid_rst_valids", {77'h0, arvalid_o, rready_o, cmd_valid_o}, 80'd0);
    chk("mid_rst_araddr", {48'h0, araddr_o}, 80'd0);
    chk("mid_rst_cmd", {cmd_src_o, cmd_dst_o, cmd_len_o}, 80'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("post_rst_idle", {79'h0, done_o}, 80'd1);
    exp_ar_q.delete();
    expect_single();
    start_chain(32'h1000);
    wait_idle(500);
    end_checks(2, 8'b01, 1'b0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sgdmac_desc_fetch.md
SGDMAC_DESC_FETCH -- requirements
Module: sgdmac_desc_fetch

Interface
REQ-001 The block SHALL have the parameter DESC_WORDS, default 4, meaning the number of 32-bit words per descriptor; it is fixed at 4 and any other value is unsupported.
REQ-002 The block SHALL have the ports listed below.
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- start_addr_i  in  32  first descriptor address, from the config block
- start_i  in  1  one-cycle start pulse, from the config block
- done_o  out  1  level; 1 = engine idle; feeds the config block's done_i
- err_o  out  1  sticky descriptor-fetch error flag
- arvalid_o  out  1  read-request valid
- araddr_o  out  32  read-request address
- arlen_o  out  4  burst length minus one; constant 3
- arready_i  in  1  read-request accept
- rvalid_i  in  1  read-data valid
- rdata_i  in  32  read data
- rresp_i  in  2  read response; nonzero = error
- rlast_i  in  1  last beat of the burst
- rready_o  out  1  read-data ready
- cmd_valid_o  out  1  transfer command valid, to the data mover
- cmd_src_o  out  32  source address
- cmd_dst_o  out  32  destination address
- cmd_len_o  out  16  byte count
- cmd_ready_i  in  1  command accept
- cmd_done_i  in  1  one-cycle pulse: the mover has finished the accepted command

Function
REQ-003 Descriptor layout (16-byte aligned) SHALL be:
- word0 = source address
- word1 = destination address
- word2[15:0] = length; bits [31:16] ignored
- word3[31:4] = next descriptor address (low nibble 0)
- word3[0] = last flag
REQ-004 The FSM SHALL have the states IDLE, FETCH_AR, FETCH_R, ISSUE, WAIT_DONE.
REQ-005 In IDLE, start_i=1 SHALL load the current pointer with {start_addr_i[31:4],4'h0}, clear err_o, and enter FETCH_AR the next cycle.
REQ-006 start_i SHALL be ignored in every state other than IDLE.
REQ-007 In FETCH_AR, the block SHALL drive arvalid_o=1 with araddr_o = current pointer and arlen_o=3, hold both stable until arready_i, and then enter FETCH_R.
REQ-008 In FETCH_R, the block SHALL hold rready_o=1, count beats 0-3 with a 2-bit counter, and capture rdata_i into descriptor word[beat] on each rvalid_i.
REQ-009 On the 4th beat, the block SHALL leave FETCH_R regardless of rlast_i.
REQ-010 The block SHALL set err_o if rlast_i is 1 on beats 0-2 or 0 on beat 3.
REQ-011 The block SHALL set err_o on any beat with rresp_i != 0.
REQ-012 After the 4th beat with err_o=1, the block SHALL go to IDLE and issue no command.
REQ-013 After the 4th beat with no error and length != 0, the block SHALL go to ISSUE.
REQ-014 After the 4th beat with no error and length == 0, the block SHALL skip the command: if the last flag is set it goes to IDLE, otherwise it loads the pointer with the next address and goes to FETCH_AR.
REQ-015 In ISSUE, the block SHALL drive cmd_valid_o=1 with cmd_src_o, cmd_dst_o and cmd_len_o stable until cmd_ready_i, and then enter WAIT_DONE.
REQ-016 In WAIT_DONE, on cmd_done_i the block SHALL go to IDLE if the last flag is set, otherwise load the next pointer and go to FETCH_AR.
REQ-017 cmd_done_i SHALL be ignored outside WAIT_DONE.
REQ-018 At most one command SHALL be outstanding, and no fetch SHALL occur while in WAIT_DONE.
REQ-019 done_o SHALL be 1 exactly when the state is IDLE, with no extra latency.
REQ-020 err_o SHALL be sticky until the next accepted start_i.
REQ-021 arvalid_o, rready_o and cmd_valid_o SHALL be registered, or decoded directly from state, and SHALL be glitch-free.
REQ-022 Pointer arithmetic SHALL be 32-bit, and a next pointer of 0 SHALL be followed literally, not treated as a terminator.

Reset
REQ-023 On rst, asynchronously, the block SHALL enter IDLE with done_o=1, err_o=0, arvalid_o=0, rready_o=0, cmd_valid_o=0, araddr_o=0, the cmd_* data outputs=0 and the beat counter=0.
REQ-024 Reset asserted in any state SHALL abandon the chain, and no command SHALL be issued after rst is released until a new start_i.

Verification
REQ-025 Single-descriptor test: start_addr_i=0x1000, mem[0x1000..]={0x2000,0x3000,0x40,0x1} -> one request at 0x1000 with arlen_o=3, then one command {0x2000,0x3000,0x40}; after cmd_done_i, done_o=1 and err_o=0.
REQ-026 Three-descriptor chain test: chain 0x100->0x200->0x300, last flag on 0x300, with cmd_ready_i delayed 5 cycles and cmd_done_i 20 cycles after each accept -> three commands in order, no fetch while in WAIT_DONE, done_o=0 throughout and 1 after the third cmd_done_i.
REQ-027 Zero-length test: the middle descriptor has length 0 -> two commands only, and the zero-length descriptor's fetch is followed directly by the fetch of its next address.
REQ-028 Error test: rresp_i=2'b10 on beat 1 of the first descriptor -> all 4 beats are consumed, no cmd_valid_o, IDLE with err_o=1; a second start_i clears err_o.
REQ-029 Stall and ignore test: start_i pulses while busy, with arready_i low for 10 cycles -> araddr_o is stable and the extra start_i pulses have no effect.
REQ-030 Reset test: rst asserted during FETCH_R beat 2 -> all outputs immediately take their reset values, and the next start_i refetches from the new start_addr_i.
